// File: rtl/pipe_ctrl_pkg.sv
// pipes: shared types and default sizes for the pipe_ctrl pipeline skeleton.
// Contents:
//   DEF_*        default parameter values used by pipe_ctrl / pipe_slot
//   stage_idx_t  index of a pipeline slot (0 = youngest)
//   pipe_cnt_t   performance counter word
//   pipe_slot_t  {valid, data} content of one slot at the default width
package pipes;

  localparam int DEF_NSTAGE = 5;
  localparam int DEF_W      = 64;
  localparam int DEF_CNT_W  = 64;

  typedef logic [$clog2(DEF_NSTAGE)-1:0] stage_idx_t;
  typedef logic [DEF_CNT_W-1:0]          pipe_cnt_t;

  typedef struct packed {
    logic             valid;
    logic [DEF_W-1:0] data;
  } pipe_slot_t;

endpackage

// File: rtl/pipe_ctrl_slot.sv
// pipe_slot: one pipeline slot register (valid + payload).
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   hold            keep current content (unless killed)
//   bubble          load an empty slot instead of the incoming content
//   kill            invalidate the next state; overrides hold
//   in_valid/in_data  content offered by the younger neighbour (or producer)
//   valid/data      current slot content
module pipe_slot
  import pipes::*;
#(
  parameter int W           = DEF_W,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         bubble,
  input  logic         kill,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  typedef struct packed {
    logic         valid;
    logic [W-1:0] data;
  } slot_t;

  slot_t slot_reg;
  slot_t slot_next;

  always_comb begin
    slot_next = slot_reg;
    if (!hold) begin
      slot_next.valid = in_valid & ~bubble;
      slot_next.data  = in_data;
    end
    if (kill) begin
      slot_next.valid = 1'b0;
    end
    // An empty slot never exposes stale payload when zeroing is enabled.
    if (ZERO_BUBBLE && !slot_next.valid) begin
      slot_next.data = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  assign valid = slot_reg.valid;
  assign data  = slot_reg.data;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: N-stage in-order pipeline skeleton with stall, bubble and
// flush control plus cycle/retire/stall counters.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   in_valid/in_data     producer payload; in_ready = slot 0 accepts
//   stall_req[i]         stage i cannot advance its content
//   flush_req[i]         kill everything younger than stage i
//   cnt_clr              synchronous clear of all counters
//   stage_valid/data     per-slot content, slot i at data[i*W +: W]
//   stage_hold           per-slot effective hold
//   out_valid/out_data   oldest slot retires this cycle
//   cycle_cnt/instr_cnt/stall_cnt  performance counters
module pipe_ctrl
  import pipes::*;
#(
  parameter int NSTAGE      = DEF_NSTAGE,
  parameter int W           = DEF_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit COLLAPSE    = 1'b0,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  input  logic [NSTAGE-1:0]   stall_req,
  input  logic [NSTAGE-1:0]   flush_req,
  input  logic                cnt_clr,
  output logic [NSTAGE-1:0]   stage_valid,
  output logic [NSTAGE*W-1:0] stage_data,
  output logic [NSTAGE-1:0]   stage_hold,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NSTAGE-1:0] hold;
  logic [NSTAGE-1:0] kill;
  logic              accept;

  // Hold propagates from the oldest slot towards the youngest. In collapse
  // mode an empty slot breaks the chain so younger content can fill it.
  always_comb begin
    logic acc;
    hold = '0;
    acc  = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (COLLAPSE) begin
        acc = stage_valid[i] & (stall_req[i] | acc);
      end else begin
        acc = stall_req[i] | acc;
      end
      hold[i] = acc;
    end
  end

  // A flush from any older stage kills the slot outright; a slot's own flush
  // only kills the younger content that would move into it.
  always_comb begin
    logic older_flush;
    kill        = '0;
    older_flush = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      kill[i]     = older_flush | (flush_req[i] & ~hold[i]);
      older_flush = older_flush | flush_req[i];
    end
  end

  assign in_ready   = reset & ~hold[0] & ~(|flush_req);
  assign accept     = in_valid & in_ready;
  assign stage_hold = reset ? hold : '0;

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_slot
    logic         prev_valid;
    logic [W-1:0] prev_data;
    logic         prev_hold;

    if (gi == 0) begin : g_head
      assign prev_valid = accept;
      assign prev_data  = in_data;
      assign prev_hold  = 1'b0;
    end else begin : g_body
      assign prev_valid = stage_valid[gi-1];
      assign prev_data  = stage_data[(gi-1)*W +: W];
      assign prev_hold  = hold[gi-1];
    end

    pipe_slot #(
      .W           (W),
      .ZERO_BUBBLE (ZERO_BUBBLE)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .hold     (hold[gi]),
      .bubble   (prev_hold),
      .kill     (kill[gi]),
      .in_valid (prev_valid),
      .in_data  (prev_data),
      .valid    (stage_valid[gi]),
      .data     (stage_data[gi*W +: W])
    );
  end

  assign out_valid = stage_valid[NSTAGE-1] & ~stall_req[NSTAGE-1];
  assign out_data  = stage_data[(NSTAGE-1)*W +: W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (out_valid) begin
        instr_cnt <= instr_cnt + CNT_ONE;
      end
      if (hold[0]) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: one default instance (COLLAPSE=0) and one
// collapse-mode instance driven by the same stimulus.
module tb_pipe_ctrl;

  localparam int NS = 5;
  localparam int W  = 64;
  localparam int CW = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic [NS-1:0]    stall_req = '0;
  logic [NS-1:0]    flush_req = '0;
  logic             cnt_clr = 1'b0;

  logic             in_ready, out_valid;
  logic [NS-1:0]    stage_valid, stage_hold;
  logic [NS*W-1:0]  stage_data;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    cycle_cnt, instr_cnt, stall_cnt;

  logic             c_in_ready, c_out_valid;
  logic [NS-1:0]    c_stage_valid, c_stage_hold;
  logic [NS*W-1:0]  c_stage_data;
  logic [W-1:0]     c_out_data;
  logic [CW-1:0]    c_cycle_cnt, c_instr_cnt, c_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGE(NS), .W(W), .CNT_W(CW), .COLLAPSE(1'b0), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
    .stage_valid(stage_valid), .stage_data(stage_data), .stage_hold(stage_hold),
    .out_valid(out_valid), .out_data(out_data),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.NSTAGE(NS), .W(W), .CNT_W(CW), .COLLAPSE(1'b1), .ZERO_BUBBLE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(c_in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
    .stage_valid(c_stage_valid), .stage_data(c_stage_data), .stage_hold(c_stage_hold),
    .out_valid(c_out_valid), .out_data(c_out_data),
    .cycle_cnt(c_cycle_cnt), .instr_cnt(c_instr_cnt), .stall_cnt(c_stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Feeds base..base+4 in cycles 0-4; returns in cycle 5 with slot0=base+4.
  task automatic fill(input logic [W-1:0] base);
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      in_data  = base + W'(i);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Holds reset for two edges, checks the reset state, then releases reset
  // so that the caller is in cycle 0 with cycle_cnt = 0.
  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    stall_req = '0; flush_req = '0; cnt_clr = 1'b0;
    tick(); tick();
    checks++; if (stage_valid !== '0) begin errors++; $display("FAIL reset_valid got %b exp 0", stage_valid); end
    checks++; if (stage_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", stage_data); end
    checks++; if (cycle_cnt !== '0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", cycle_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (c_stage_valid !== '0) begin errors++; $display("FAIL reset_c_valid got %b exp 0", c_stage_valid); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    $display("reset: done, in_ready=%b", in_ready);
  endtask

  task automatic test_back_to_back;
    test_reset();
    fill(64'd1);
    for (int c = 5; c <= 9; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(c - 4)) begin
        errors++; $display("FAIL b2b_retire cycle %0d got v=%b d=%0d exp v=1 d=%0d", c, out_valid, out_data, c - 4);
      end
      $display("b2b: cycle %0d out_valid=%b out_data=%0d", c, out_valid, out_data);
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
    checks++; if (instr_cnt !== 64'd5) begin errors++; $display("FAIL b2b_instr got %0d exp 5", instr_cnt); end
    checks++; if (stall_cnt !== 64'd0) begin errors++; $display("FAIL b2b_stall got %0d exp 0", stall_cnt); end
    checks++; if (cycle_cnt !== 64'd10) begin errors++; $display("FAIL b2b_cycle got %0d exp 10", cycle_cnt); end
  endtask

  task automatic test_stall;
    test_reset();
    fill(64'h100);
    // cycle 5: stall stage 2 for three cycles, producer keeps offering
    stall_req = 5'b00100; in_valid = 1'b1; in_data = 64'h1FF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    checks++; if (stage_hold !== 5'b00111) begin errors++; $display("FAIL stall_hold got %b exp 00111", stage_hold); end
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h100) begin errors++; $display("FAIL stall_retA got v=%b d=%h exp 1/100", out_valid, out_data); end
    tick(); // cycle 6
    checks++; if (stage_valid !== 5'b10111) begin errors++; $display("FAIL stall_valid6 got %b exp 10111", stage_valid); end
    checks++; if (stage_data[3*W +: W] !== 64'd0) begin errors++; $display("FAIL stall_bubble_data got %h exp 0", stage_data[3*W +: W]); end
    checks++; if (stage_data[0 +: W] !== 64'h104 || stage_data[2*W +: W] !== 64'h102) begin
      errors++; $display("FAIL stall_frozen got s0=%h s2=%h exp 104/102", stage_data[0 +: W], stage_data[2*W +: W]); end
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h101) begin errors++; $display("FAIL stall_retB got v=%b d=%h exp 1/101", out_valid, out_data); end
    $display("stall: cycle 6 valid=%b", stage_valid);
    tick(); // cycle 7
    checks++; if (stage_valid !== 5'b00111) begin errors++; $display("FAIL stall_valid7 got %b exp 00111", stage_valid); end
    tick(); // cycle 8
    stall_req = '0; in_valid = 1'b0; in_data = '0;
    checks++; if (stall_cnt !== 64'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
    tick(); tick(); // cycle 10
    for (int c = 10; c <= 12; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(64'h102 + 64'(c - 10))) begin
        errors++; $display("FAIL stall_resume cycle %0d got v=%b d=%h", c, out_valid, out_data);
      end
      $display("stall: cycle %0d out_valid=%b out_data=%h", c, out_valid, out_data);
      tick();
    end
    checks++; if (instr_cnt !== 64'd5) begin errors++; $display("FAIL stall_instr got %0d exp 5", instr_cnt); end
  endtask

  task automatic test_flush;
    test_reset();
    fill(64'h200);
    flush_req = 5'b01000; in_valid = 1'b1; in_data = 64'h2FF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    flush_req = '0; in_valid = 1'b0; in_data = '0;
    checks++; if (stage_valid !== 5'b10000) begin errors++; $display("FAIL flush_valid got %b exp 10000", stage_valid); end
    checks++; if (stage_data !== {64'h201, 64'd0, 64'd0, 64'd0, 64'd0}) begin errors++; $display("FAIL flush_data got %h", stage_data); end
    $display("flush: valid=%b out_data=%h", stage_valid, out_data);
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cycle %0d got %b exp 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_collapse;
    logic [NS-1:0] mask;
    test_reset();
    mask = 5'b10111; // producer order A,B,C,gap,E
    for (int i = 0; i < NS; i++) begin
      in_valid = mask[i];
      in_data  = 64'h300 + 64'(i);
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    stall_req = 5'b10000;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nocollapse_in_ready got %b exp 0", in_ready); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL collapse_in_ready got %b exp 1", c_in_ready); end
    checks++; if (stage_hold !== 5'b11111) begin errors++; $display("FAIL nocollapse_hold got %b exp 11111", stage_hold); end
    checks++; if (c_stage_hold !== 5'b11100) begin errors++; $display("FAIL collapse_hold got %b exp 11100", c_stage_hold); end
    tick();
    checks++; if (stage_valid !== 5'b11101) begin errors++; $display("FAIL nocollapse_valid got %b exp 11101", stage_valid); end
    checks++; if (c_stage_valid !== 5'b11110) begin errors++; $display("FAIL collapse_valid got %b exp 11110", c_stage_valid); end
    checks++; if (c_stage_data[W +: W] !== 64'h304) begin errors++; $display("FAIL collapse_move got %h exp 304", c_stage_data[W +: W]); end
    $display("collapse: plain=%b collapse=%b", stage_valid, c_stage_valid);
    stall_req = '0;
  endtask

  task automatic test_flush_over_hold;
    test_reset();
    fill(64'h400);
    stall_req = 5'b00010; flush_req = 5'b01000;
    tick();
    stall_req = '0; flush_req = '0;
    checks++; if (stage_valid !== 5'b10000) begin errors++; $display("FAIL flushhold_valid got %b exp 10000", stage_valid); end
    checks++; if (out_data !== 64'h401) begin errors++; $display("FAIL flushhold_data got %h exp 401", out_data); end
    $display("flush_over_hold: valid=%b", stage_valid);
  endtask

  task automatic test_async_reset_and_clear;
    test_reset();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 64'(i); tick();
    end
    stall_req = 5'b00001;
    #3;
    reset = 1'b0;
    #1;
    checks++; if (stage_valid !== '0) begin errors++; $display("FAIL async_valid got %b exp 0", stage_valid); end
    checks++; if (cycle_cnt !== '0) begin errors++; $display("FAIL async_cycle got %0d exp 0", cycle_cnt); end
    checks++; if (stage_hold !== '0) begin errors++; $display("FAIL async_hold got %b exp 0", stage_hold); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_in_ready got %b exp 0", in_ready); end
    $display("async_reset: valid=%b cycle_cnt=%0d", stage_valid, cycle_cnt);
    in_valid = 1'b0; in_data = '0; stall_req = '0;
    tick();
    reset = 1'b1; // cycle 0
    in_valid = 1'b1; in_data = 64'h77;
    tick();
    in_valid = 1'b0; in_data = '0;
    tick(); tick(); tick(); tick(); // cycle 5
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h77) begin errors++; $display("FAIL clr_retire got v=%b d=%h exp 1/77", out_valid, out_data); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (instr_cnt !== 64'd0) begin errors++; $display("FAIL clr_instr got %0d exp 0", instr_cnt); end
    checks++; if (cycle_cnt !== 64'd0) begin errors++; $display("FAIL clr_cycle got %0d exp 0", cycle_cnt); end
    tick();
    checks++; if (cycle_cnt !== 64'd1) begin errors++; $display("FAIL clr_cycle_next got %0d exp 1", cycle_cnt); end
    $display("cnt_clr: instr_cnt=%0d cycle_cnt=%0d", instr_cnt, cycle_cnt);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_collapse();
    test_flush_over_hold();
    test_async_reset_and_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised N-stage in-order pipeline skeleton that holds the per-stage payload registers and generates all stall, bubble and flush control.
- Generalises the fixed 5-stage stall chain and the bubble-on-stall behaviour of the core to any depth and payload width.
- Adds multi-stage flush, an optional bubble-collapse mode, and cycle/retire/stall counters that feed difftest trap reporting.
- Sits inside the core between fetch (producer) and writeback (consumer).

Parameters:
- NSTAGE, 5, number of pipeline slots; slot 0 is youngest, slot NSTAGE-1 is oldest (retiring).
- W, 64, payload width per slot in bits.
- CNT_W, 64, counter width.
- COLLAPSE, 0, 1 = an empty slot does not propagate a downstream hold, so bubbles are squeezed out.
- ZERO_BUBBLE, 1, 1 = a slot's data is cleared to 0 whenever that slot becomes invalid.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a payload.
- in_data  in  W  producer payload.
- in_ready  out  1  slot 0 accepts this cycle.
- stall_req  in  NSTAGE  bit i = stage i cannot advance its content.
- flush_req  in  NSTAGE  bit i = kill everything younger than stage i.
- cnt_clr  in  1  synchronous clear of all counters.
- stage_valid  out  NSTAGE  per-slot valid.
- stage_data  out  NSTAGE*W  per-slot payload; slot i occupies bits [i*W +: W].
- stage_hold  out  NSTAGE  per-slot effective hold, for enable gating of side logic.
- out_valid  out  1  slot NSTAGE-1 retires this cycle.
- out_data  out  W  retiring payload.
- cycle_cnt  out  CNT_W  cycles since reset or clear.
- instr_cnt  out  CNT_W  retirements.
- stall_cnt  out  CNT_W  cycles with stage_hold[0]=1.

Behaviour:
- Reset asserted (reset=0), effective immediately without a clock edge:
  - all stage_valid=0, all stage_data=0, all counters=0;
  - out_valid=0, in_ready=0, stage_hold=0.
- Reset deassertion takes effect at the next rising edge; reset mid-stream discards all in-flight slots.
- Hold chain (combinational), with hold[NSTAGE] = 0:
  - COLLAPSE=0: hold[i] = stall_req[i] | hold[i+1]. A stall_req on an empty slot is still honoured.
  - COLLAPSE=1: hold[i] = stage_valid[i] & (stall_req[i] | hold[i+1]).
- stage_hold = hold[NSTAGE-1:0].
- in_ready = !hold[0] & !(|flush_req), and 0 while reset is asserted. Accept = in_valid & in_ready.
- Slot update at each rising edge, for slot k:
  - if hold[k], keep current content;
  - else load slot k-1 content (for k=0, the accepted input; a bubble if no accept).
  - If hold[k-1] & !hold[k] (k>0), slot k loads a bubble.
- Flush kills slot k's next state when either condition holds:
  - some flush_req[j] is set with j > k; or
  - flush_req[k] is set and slot k is not held (its incoming younger content dies).
- The flushing slot itself is never killed by its own flush_req. Flush overrides hold.
- Simultaneous flush_req bits behave as the OR of the individual flushes, so the oldest requester dominates.
- Retire: out_valid = stage_valid[NSTAGE-1] & !stall_req[NSTAGE-1]; out_data = stage_data[NSTAGE-1]. There is no consumer back-pressure beyond stall_req.
- Latency: a payload accepted in cycle t occupies slot i in cycle t+1+i and retires in cycle t+NSTAGE when no stalls occur.
- Counters:
  - cycle_cnt increments every cycle;
  - instr_cnt increments when out_valid=1;
  - stall_cnt increments when hold[0]=1;
  - all counters wrap at 2^CNT_W; cnt_clr has priority over increment.

Decomposition:
- Package pipes: stage_idx_t (clog2 NSTAGE), pipe_cnt_t, and a pipe_slot_t struct {valid, data}.
- One natural sub-module, pipe_slot: a single slot register with inputs hold, bubble and kill. It is instantiated NSTAGE times in a generate loop.
- Hold, kill and counter logic stay in pipe_ctrl.

Test Plan:
1. NSTAGE=5, W=64; present in_data 1..5 back-to-back from cycle 0 -> out_valid with out_data=1 in cycle 5, then 2..5 in cycles 6-9; instr_cnt=5, stall_cnt=0.
2. Full pipe holding A..E (slot0=E); stall_req[2]=1 for 3 cycles -> slots 0-2 frozen, slot 3 becomes bubble with data 0, in_ready=0, stall_cnt=3; slot 4 retires, then the pipe resumes in order.
3. Full pipe; flush_req[3]=1 for one cycle -> next cycle stage_valid=5'b10000 (slot 4 holds the flusher), in_ready=0 during the flush cycle, no stale payload retires.
4. COLLAPSE=1; slot 1 invalid, all others valid, stall_req[4]=1 -> slot 0 moves into slot 1, slots 2-4 hold, in_ready=1. With COLLAPSE=0 the same stimulus -> in_ready=0 and all slots hold.
5. stall_req[1]=1 with flush_req[3]=1 in the same cycle -> slots 0-3 invalid next cycle despite the hold.
6. Drive reset low mid-stream between clock edges -> stage_valid=0 and counters=0 immediately; cnt_clr=1 together with a retirement -> instr_cnt=0.
